// File: rtl/systolic_mm_core.sv
// N x N output-stationary systolic matrix-multiply core (C = A x B) with internal
// input skewing, valid/ready beat intake, start/busy/done control and row readout.
module systolic_mm_core #(
  parameter int N      = 4,
  parameter int DW     = 8,
  parameter int KMAX   = 16,
  parameter int KW     = 5,
  parameter int AW     = 2*DW+$clog2(KMAX),
  parameter bit SIGNED = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*DW-1:0]      a_col,
  input  logic [N*DW-1:0]      b_row,
  output logic                 busy,
  output logic                 done,
  input  logic [$clog2(N)-1:0] rd_row,
  output logic [N*AW-1:0]      rd_data
);
  // state | meaning
  // IDLE  | after reset, waiting for start
  // LOAD  | accepting beats, cnt = beats still expected
  // DRAIN | flushing the skew/PE pipeline, cnt = cycles left
  // DONE  | results final, waiting for start
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  localparam int CW = (KW > $clog2(2*N)) ? KW : $clog2(2*N);
  localparam logic [CW-1:0] DRAIN_CNT = CW'(2*N-1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          done_q, done_n;
  logic [KW-1:0] k_eff;
  logic          accept, clr;

  assign k_eff    = (k_len > KW'(KMAX)) ? KW'(KMAX) : k_len;
  assign in_ready = (state == LOAD);
  assign busy     = (state == LOAD) || (state == DRAIN);
  assign done     = done_q;
  assign accept   = (state == LOAD) && in_valid;
  assign clr      = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    done_n  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (k_eff == '0) begin
            state_n = DRAIN;
            cnt_n   = DRAIN_CNT;
          end else begin
            state_n = LOAD;
            cnt_n   = CW'(k_eff);
          end
        end
      end
      LOAD: begin
        if (in_valid) begin
          if (cnt == CW'(1)) begin
            state_n = DRAIN;
            cnt_n   = DRAIN_CNT;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
      end
      DRAIN: begin
        if (cnt == '0) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  logic [DW-1:0] a_in [N];
  logic [DW-1:0] b_in [N];
  logic [DW-1:0] a_ent [N];
  logic [DW-1:0] b_ent [N];
  logic [DW-1:0] a_sk [N][N];
  logic [DW-1:0] b_sk [N][N];
  logic [DW-1:0] a_sk_d [N][N];
  logic [DW-1:0] b_sk_d [N][N];
  logic [DW-1:0] a_pe [N][N];
  logic [DW-1:0] b_pe [N][N];
  logic [DW-1:0] a_left [N][N];
  logic [DW-1:0] b_top [N][N];
  logic [AW-1:0] acc [N][N];
  logic [AW-1:0] prod_ext [N][N];

  // Idle cycles inject zeros so bubbles contribute nothing to the sums.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_in[i] = accept ? a_col[i*DW +: DW] : '0;
      b_in[i] = accept ? b_row[i*DW +: DW] : '0;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    for (genvar d = 0; d < N; d++) begin : g_sk
      if (d == 0) begin : g_first
        assign a_sk_d[i][d] = a_in[i];
        assign b_sk_d[i][d] = b_in[i];
      end else begin : g_chain
        assign a_sk_d[i][d] = a_sk[i][d-1];
        assign b_sk_d[i][d] = b_sk[i][d-1];
      end
    end
    if (i == 0) begin : g_direct
      assign a_ent[i] = a_in[i];
      assign b_ent[i] = b_in[i];
    end else begin : g_delayed
      assign a_ent[i] = a_sk[i][i-1];
      assign b_ent[i] = b_sk[i][i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [2*DW-1:0] p;
      logic            sa, sb;
      if (j == 0) begin : g_aw
        assign a_left[i][j] = a_ent[i];
      end else begin : g_ap
        assign a_left[i][j] = a_pe[i][j-1];
      end
      if (i == 0) begin : g_bn
        assign b_top[i][j] = b_ent[j];
      end else begin : g_bp
        assign b_top[i][j] = b_pe[i-1][j];
      end
      // Low 2*DW bits of the extended product equal the signed or unsigned product.
      assign sa = SIGNED & a_pe[i][j][DW-1];
      assign sb = SIGNED & b_pe[i][j][DW-1];
      assign p  = {{DW{sa}}, a_pe[i][j]} * {{DW{sb}}, b_pe[i][j]};
      assign prod_ext[i][j] = {{(AW-2*DW){SIGNED & p[2*DW-1]}}, p};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_sk[i][j] <= '0;
          b_sk[i][j] <= '0;
          a_pe[i][j] <= '0;
          b_pe[i][j] <= '0;
          acc[i][j]  <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_sk[i][j] <= a_sk_d[i][j];
          b_sk[i][j] <= b_sk_d[i][j];
          a_pe[i][j] <= a_left[i][j];
          b_pe[i][j] <= b_top[i][j];
          acc[i][j]  <= clr ? '0 : acc[i][j] + prod_ext[i][j];
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int j = 0; j < N; j++) rd_data[j*AW +: AW] = acc[rd_row][j];
  end
endmodule

// File: tb/tb_systolic_mm_core.sv
// Directed bench for systolic_mm_core: unsigned and signed instances share stimulus;
// result tables, latencies and control corner cases are checked against hand values.
module tb_systolic_mm_core;
  localparam int N = 4, DW = 8, KMAX = 16, KW = 5, AW = 2*DW+$clog2(KMAX);

  logic clk = 1'b0;
  logic rst, start, in_valid;
  logic [KW-1:0] k_len;
  logic [N*DW-1:0] a_col, b_row;
  logic [1:0] rd_row;
  logic in_ready, busy, done, s_in_ready, s_busy, s_done;
  logic [N*AW-1:0] rd_data, s_rd_data;

  systolic_mm_core #(.N(N), .DW(DW), .KMAX(KMAX), .KW(KW), .AW(AW), .SIGNED(1'b0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid),
    .in_ready(in_ready), .a_col(a_col), .b_row(b_row), .busy(busy), .done(done),
    .rd_row(rd_row), .rd_data(rd_data));

  systolic_mm_core #(.N(N), .DW(DW), .KMAX(KMAX), .KW(KW), .AW(AW), .SIGNED(1'b1)) u_sdut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid),
    .in_ready(s_in_ready), .a_col(a_col), .b_row(b_row), .busy(s_busy), .done(s_done),
    .rd_row(rd_row), .rd_data(s_rd_data));

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {int row; int col; int exp;} vec_t;
  vec_t tbl[16];
  int am[N][KMAX];
  int bm[KMAX][N];
  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic read_c(input int r, input int c, input bit s, output logic [AW-1:0] v);
    rd_row = 2'(r);
    #1;
    v = s ? s_rd_data[c*AW +: AW] : rd_data[c*AW +: AW];
  endtask

  task automatic fill_mats(input int av, input int bv);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < KMAX; k++) begin
        am[i][k] = av;
        bm[k][i] = bv;
      end
  endtask

  task automatic set_job1();
    int a1[4][4] = '{'{10,9,7,5}, '{8,3,3,2}, '{3,2,10,8}, '{8,4,3,3}};
    int b1[4][4] = '{'{3,12,4,10}, '{9,10,12,2}, '{12,1,4,9}, '{3,10,12,18}};
    fill_mats(0, 0);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        am[i][k] = a1[i][k];
        bm[k][i] = b1[k][i];
      end
  endtask

  task automatic drive_beat(input int k);
    in_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      a_col[i*DW +: DW] = DW'(am[i][k]);
      b_row[i*DW +: DW] = DW'(bm[k][i]);
    end
  endtask

  task automatic run_job(input int klen, input int nbeats, input int gap_at, input int gap_len,
                         input bit start_mid, output int lat);
    int t0;
    bit got;
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(klen);
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    for (int k = 0; k < nbeats; k++) begin
      if (k == gap_at) begin
        in_valid = 1'b0;
        repeat (gap_len) @(negedge clk);
      end
      drive_beat(k);
      if (start_mid && k == 2) begin
        start = 1'b1;
        k_len = '0;
      end
      @(negedge clk);
      start = 1'b0;
      if (k == 0) t0 = cyc;
    end
    in_valid = 1'b0;
    a_col = '0;
    b_row = '0;
    got = 1'b0;
    lat = -1;
    for (int w = 0; w < 300 && !got; w++) begin
      if (done) begin
        got = 1'b1;
        lat = cyc - t0;
      end else begin
        @(negedge clk);
      end
    end
    chk("done_seen", 64'(got), 64'd1);
    if (got) begin
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'd0);
    end
  endtask

  task automatic check_table(input string tag);
    logic [AW-1:0] v;
    for (int n = 0; n < 16; n++) begin
      read_c(tbl[n].row, tbl[n].col, 1'b0, v);
      chk($sformatf("%s C[%0d][%0d]", tag, tbl[n].row, tbl[n].col), 64'(v), 64'(tbl[n].exp));
    end
  endtask

  task automatic check_all(input string tag, input int exp);
    logic [AW-1:0] v;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        read_c(r, c, 1'b0, v);
        chk($sformatf("%s C[%0d][%0d]", tag, r, c), 64'(v), 64'(exp));
      end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cexp[4][4] = '{'{210,267,236,271}, '{93,149,104,149}, '{171,146,172,268}, '{105,169,128,169}};
    int lat;
    bit seen;
    logic [AW-1:0] v;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) tbl[r*4+c] = '{r, c, cexp[r][c]};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; k_len = '0;
    a_col = '0; b_row = '0; rd_row = '0;
    #3;
    chk("reset in_ready", 64'(in_ready), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset s_done", 64'(s_done), 64'd0);
    for (int r = 0; r < N; r++) begin
      rd_row = 2'(r);
      #1;
      chk($sformatf("reset rd_data row %0d", r), 64'(rd_data), 64'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    set_job1();
    run_job(4, 4, -1, 0, 1'b0, lat);
    chk("job1 latency", 64'(lat), 64'd11);
    check_table("job1");

    run_job(4, 4, 2, 2, 1'b0, lat);
    chk("gap latency", 64'(lat), 64'd13);
    check_table("gap");

    run_job(4, 4, -1, 0, 1'b1, lat);
    chk("start_mid latency", 64'(lat), 64'd11);
    check_table("start_mid");

    run_job(0, 0, -1, 0, 1'b0, lat);
    chk("k0 latency", 64'(lat), 64'd8);
    check_all("k0", 0);

    fill_mats(0, 0);
    am[0][0] = -128; am[0][1] = -1; bm[0][0] = -128; bm[1][0] = 1;
    run_job(2, 2, -1, 0, 1'b0, lat);
    read_c(0, 0, 1'b1, v);
    chk("signed C00 a", 64'(v), 64'd16383);
    read_c(0, 0, 1'b0, v);
    chk("unsigned C00 a", 64'(v), 64'd16639);
    read_c(1, 1, 1'b1, v);
    chk("signed C11 a", 64'(v), 64'd0);

    fill_mats(0, 0);
    am[0][0] = -3; bm[0][0] = 5;
    run_job(2, 2, -1, 0, 1'b0, lat);
    read_c(0, 0, 1'b1, v);
    chk("signed C00 b", 64'(v), 64'h0_FFFF1);
    read_c(0, 0, 1'b0, v);
    chk("unsigned C00 b", 64'(v), 64'd1265);

    set_job1();
    @(negedge clk);
    start = 1'b1; k_len = KW'(4);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_beat(k);
      @(negedge clk);
    end
    in_valid = 1'b0; a_col = '0; b_row = '0;
    repeat (2) @(negedge clk);
    chk("pre-abort busy", 64'(busy), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort in_ready", 64'(in_ready), 64'd0);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    for (int r = 0; r < N; r++) begin
      rd_row = 2'(r);
      #1;
      chk($sformatf("abort rd_data row %0d", r), 64'(rd_data), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("abort stays idle", 64'(seen), 64'd0);
    run_job(4, 4, -1, 0, 1'b0, lat);
    chk("post-abort latency", 64'(lat), 64'd11);
    check_table("post-abort");

    fill_mats(255, 255);
    run_job(16, 16, -1, 0, 1'b0, lat);
    chk("kmax latency", 64'(lat), 64'd23);
    check_all("kmax", 1040400);

    fill_mats(1, 1);
    run_job(31, 16, -1, 0, 1'b0, lat);
    chk("clamp latency", 64'(lat), 64'd23);
    check_all("clamp", 16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
